// File: rtl/exu_alu_mdu_ysyx_23060136_if.sv
// Handshake and operand/result bundle between the EXU operand mux, the ALU/MDU and the EXU->LSU register.
interface exu_alu_mdu_ysyx_23060136_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [4:0]      op_i;
  logic [XLEN-1:0] da_i;
  logic [XLEN-1:0] db_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            less_o;

  modport slave (
    input  flush_i, in_valid_i, op_i, da_i, db_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, less_o
  );

  modport master (
    output flush_i, in_valid_i, op_i, da_i, db_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, less_o
  );
endinterface

// File: rtl/exu_alu_mdu_ysyx_23060136.sv
// Execute-stage ALU plus RV32M multiply/divide: single-cycle ALU ops, iterative shift-add multiply
// and restoring divide with a final sign-correction step.
module exu_alu_mdu_ysyx_23060136 #(
  parameter int unsigned XLEN     = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  exu_alu_mdu_ysyx_23060136_if.slave         bus
);
  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3,
                         OP_OR  = 5'd4,  OP_AND = 5'd5,  OP_XOR = 5'd6,  OP_SLL  = 5'd7,
                         OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd11, OP_MULH = 5'd12,
                         OP_MULHSU = 5'd13, OP_MULHU = 5'd14, OP_DIV = 5'd15, OP_DIVU = 5'd16,
                         OP_REM = 5'd17, OP_REMU = 5'd18;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_accept, w_iter_start, w_in_ready;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid, r_zero, r_less;
  logic [SW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_rem, r_quo, r_dvs;
  logic              r_neg_q, r_neg_r, r_is_div, r_is_rem, r_mul_hi;

  // Shared subtract drives SUB/SLT/SLTU and the branch-compare flags
  logic [XLEN:0]     w_sub;
  logic [XLEN-1:0]   w_diff;
  logic              w_ovf, w_less_s, w_less_u, w_zero;
  assign w_sub    = {1'b0, bus.da_i} + {1'b0, ~bus.db_i} + (XLEN+1)'(1);
  assign w_diff   = w_sub[XLEN-1:0];
  assign w_ovf    = (bus.da_i[XLEN-1] ^ bus.db_i[XLEN-1]) & (bus.da_i[XLEN-1] ^ w_diff[XLEN-1]);
  assign w_less_s = w_ovf ^ w_diff[XLEN-1];
  assign w_less_u = ~w_sub[XLEN];
  assign w_zero   = (w_diff == '0);

  logic [SW-1:0] w_shamt;
  logic          w_is_mul, w_is_div, w_div_zero, w_div_ovf, w_div_special, w_iter_op;
  logic          w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  assign w_shamt       = bus.db_i[SW-1:0];
  assign w_is_mul      = (bus.op_i >= OP_MUL) && (bus.op_i <= OP_MULHU);
  assign w_is_div      = (bus.op_i >= OP_DIV) && (bus.op_i <= OP_REMU);
  assign w_div_zero    = (bus.db_i == '0);
  assign w_div_ovf     = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                         (bus.da_i == MIN_INT) && (bus.db_i == '1);
  assign w_div_special = w_is_div & (w_div_zero | w_div_ovf);
  assign w_iter_op     = (w_is_mul & ~FAST_MUL) | (w_is_div & ~w_div_special);
  assign w_a_sgn       = (bus.op_i == OP_MUL) || (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                         (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
  assign w_b_sgn       = (bus.op_i == OP_MUL) || (bus.op_i == OP_MULH) ||
                         (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
  assign w_a_neg       = w_a_sgn & bus.da_i[XLEN-1];
  assign w_b_neg       = w_b_sgn & bus.db_i[XLEN-1];
  assign w_a_mag       = w_a_neg ? -bus.da_i : bus.da_i;
  assign w_b_mag       = w_b_neg ? -bus.db_i : bus.db_i;

  // Single-cycle multiplier: sign-extend to 2*XLEN so the truncated product is exact
  logic [2*XLEN-1:0] w_prod_fast;
  assign w_prod_fast = {{XLEN{w_a_neg}}, bus.da_i} * {{XLEN{w_b_neg}}, bus.db_i};

  logic [XLEN-1:0] w_res_single;
  always_comb begin
    w_res_single = bus.db_i;
    case (bus.op_i)
      OP_ADD:    w_res_single = bus.da_i + bus.db_i;
      OP_SUB:    w_res_single = w_diff;
      OP_SLT:    w_res_single = XLEN'(w_less_s);
      OP_SLTU:   w_res_single = XLEN'(w_less_u);
      OP_OR:     w_res_single = bus.da_i | bus.db_i;
      OP_AND:    w_res_single = bus.da_i & bus.db_i;
      OP_XOR:    w_res_single = bus.da_i ^ bus.db_i;
      OP_SLL:    w_res_single = bus.da_i << w_shamt;
      OP_SRL:    w_res_single = bus.da_i >> w_shamt;
      OP_SRA:    w_res_single = $unsigned($signed(bus.da_i) >>> w_shamt);
      OP_MUL:    w_res_single = w_prod_fast[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_res_single = w_prod_fast[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: w_res_single = w_div_zero ? '1 : MIN_INT;
      OP_REM, OP_REMU: w_res_single = w_div_zero ? bus.da_i : '0;
      default:   w_res_single = bus.db_i;
    endcase
  end

  // One iteration step: r_rem is the running high half / partial remainder, r_quo the shifting low half
  logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;
  assign w_mul_sum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : '0);
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_dvs};

  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_res_iter;
  always_comb begin
    w_prod_fix = r_neg_q ? -{r_rem, r_quo} : {r_rem, r_quo};
    w_res_iter = r_mul_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
    if (r_is_div)
      w_res_iter = r_is_rem ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quo : r_quo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_iter_start = 1'b0;
    w_in_ready   = (r_state == S_IDLE) & (~r_out_valid | bus.out_ready_i);
    case (r_state)
      S_IDLE: if (bus.in_valid_i && w_in_ready) begin
        w_accept = 1'b1;
        if (w_iter_op) begin
          w_iter_start = 1'b1;
          w_state_nxt  = S_ITER;
        end
      end
      S_ITER: if (r_cnt == SW'(XLEN-1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_nxt  = S_IDLE;
      w_accept     = 1'b0;
      w_iter_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0; r_out_valid <= 1'b0; r_zero <= 1'b0; r_less <= 1'b0; r_cnt <= '0;
      r_rem <= '0; r_quo <= '0; r_dvs <= '0;
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_is_div <= 1'b0; r_is_rem <= 1'b0; r_mul_hi <= 1'b0;
    end else if (bus.flush_i) begin
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && bus.out_ready_i) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_zero <= w_zero;
        r_less <= (bus.op_i == OP_SLTU) ? w_less_u : w_less_s;
        if (!w_iter_op) begin
          r_result    <= w_res_single;
          r_out_valid <= 1'b1;
        end
      end
      if (w_iter_start) begin
        r_rem    <= '0;
        r_quo    <= w_is_div ? w_a_mag : w_b_mag;
        r_dvs    <= w_is_div ? w_b_mag : w_a_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_is_div <= w_is_div;
        r_is_rem <= (bus.op_i == OP_REM) || (bus.op_i == OP_REMU);
        r_mul_hi <= (bus.op_i != OP_MUL);
        r_cnt    <= '0;
      end
      if (r_state == S_ITER) begin
        r_cnt <= (r_cnt == SW'(XLEN-1)) ? '0 : r_cnt + SW'(1);
        if (r_is_div) begin
          r_rem <= w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], ~w_div_diff[XLEN]};
        end else begin
          r_rem <= w_mul_sum[XLEN:1];
          r_quo <= {w_mul_sum[0], r_quo[XLEN-1:1]};
        end
      end
      if (r_state == S_FIX) begin
        r_result    <= w_res_iter;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.zero_o      = r_zero;
  assign bus.less_o      = r_less;
endmodule
